stage5_fwd_scoreboard: RTL and testbench
========================================

STAGE5_FWD_SCOREBOARD -- requirements
Module: stage5_fwd_scoreboard

Interface
REQ-001 Parameters SHALL be: NUM_SRC, default 2, number of execute-stage source operands; NUM_FWD, default 2, number of forwarding producer stages (index 0 youngest, i.e. mem; index NUM_FWD-1 oldest, i.e. wb); MAX_OUT, default 4, maximum outstanding multicycle ops.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 CLK  input  1  rising-edge clock.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 src_valid  input  NUM_SRC  operand s is architecturally read this cycle.
REQ-006 src_reg  input  NUM_SRC x 5  source register index per operand.
REQ-007 fwd_wen  input  NUM_FWD  producer stage k writes a register.
REQ-008 fwd_rd  input  NUM_FWD x 5  destination register of producer stage k.
REQ-009 fwd_rdy  input  NUM_FWD  producer data valid this cycle (0 for a load still in mem).
REQ-010 fwd_sel  output  NUM_SRC x FSEL_W  0 = register file, k+1 = producer stage k.
REQ-011 mc_issue / mc_rd  input  1 / 5  multicycle op (mul/div) issues with destination mc_rd.
REQ-012 mc_done / mc_done_rd  input  1 / 5  multicycle op completes and writes mc_done_rd.
REQ-013 stall  output  1  hold execute and earlier stages.
REQ-014 mc_full / busy_vec / sb_err  output  1 / 32 / 1  outstanding count equals MAX_OUT; per-register busy bits; protocol-error pulse.

Function
REQ-015 For each operand s, fwd_sel SHALL select the youngest stage k with fwd_wen[k]=1 and fwd_rd[k]=src_reg[s]; if no stage matches, it SHALL select 0. The select is combinational with zero latency.
REQ-016 Register x0 SHALL never forward: fwd_sel=0 whenever src_reg[s]=0.
REQ-017 A load-use hazard SHALL exist when the selected stage has fwd_rdy=0 and src_valid[s]=1; the hazard SHALL assert stall in the same cycle.
REQ-018 A scoreboard hazard SHALL exist when src_valid[s]=1, src_reg[s]!=0 and the registered busy_vec bit for src_reg[s] is 1; the hazard SHALL assert stall.
REQ-019 The scoreboard hazard SHALL use only registered busy bits: an mc_done for that register in the same cycle still stalls, and the stall clears in the next cycle.
REQ-020 A structural stall SHALL be raised when mc_issue=1 and mc_full=1.
REQ-021 A WAW stall SHALL be raised when mc_issue=1 and busy_vec[mc_rd]=1, unless mc_done=1 with mc_done_rd=mc_rd in the same cycle.
REQ-022 An issue SHALL be accepted only when mc_issue=1 and stall=0; on acceptance, busy_vec[mc_rd] SHALL be set at the next edge (never for mc_rd=0) and the outstanding count SHALL increment.
REQ-023 mc_done SHALL clear busy_vec[mc_done_rd] and decrement the count at the next edge.
REQ-024 If an accepted issue and a done occur in the same cycle, the count SHALL be unchanged.
REQ-025 If an accepted issue and a done target the same register in the same cycle, the set SHALL win and the bit SHALL remain 1.
REQ-026 If mc_done targets a non-busy register, or arrives with count=0, sb_err SHALL pulse for 1 cycle, and busy_vec and the count SHALL be unchanged.
REQ-027 The count SHALL never exceed MAX_OUT and SHALL never go below 0.

Reset
REQ-028 On RST, at the clock edge: busy_vec=0, count=0, sb_err=0, mc_full=0. Combinational outputs SHALL reflect the cleared state, so stall is driven only by the load-use check.
REQ-029 RST asserted with ops outstanding SHALL discard them; a later mc_done SHALL then raise sb_err.

Configuration
REQ-030 Macro STAGE5_SCOREBOARD_EN, when defined, SHALL include REQ-018 to REQ-027 and REQ-029.
REQ-031 When STAGE5_SCOREBOARD_EN is undefined, the scoreboard SHALL be absent: busy_vec=0, mc_full=0, sb_err=0; mc_* inputs SHALL be ignored; stall SHALL come from load-use only.

Structure
REQ-032 The shared package SHALL hold FSEL_W (clog2 of NUM_FWD+1), the regidx_t 5-bit typedef, and the fwd_sel_t encoding constant FWD_RF=0.
REQ-033 The structure SHALL use one sub-module, stage5_fwd_prio_sel (one per operand, generate loop), performing the youngest-match priority select; the scoreboard SHALL be implemented in the top level.

Verification
REQ-034 Test: src_reg[0]=5; fwd stage0 and stage1 both write x5 with rdy=1 -> fwd_sel[0]=1, stall=0.
REQ-035 Test: src_reg[1]=0; stage0 writes x0 -> fwd_sel[1]=0.
REQ-036 Test: load in stage0 to x7 with rdy=0; src_reg[0]=7 valid -> stall=1; next cycle with the load in stage1 and rdy=1 -> fwd_sel[0]=2, stall=0.
REQ-037 Test: issue mc_rd=9; the next cycle reads x9 -> stall=1 until the cycle after mc_done_rd=9, and busy_vec[9] goes 1 then 0.
REQ-038 Test: four issues to x1..x4 with MAX_OUT=4 -> mc_full=1; a fifth issue -> stall=1; with mc_done x1 in the same cycle, the issue is still stalled that cycle and accepted the next.
REQ-039 Test: mc_done_rd=12 with x12 not busy -> sb_err=1 for 1 cycle and count unchanged; with the macro undefined -> sb_err=0 always.

Source files
------------

// File: rtl/stage5_fwd_scoreboard_pkg.sv
// Shared definitions for the stage-5 forwarding / scoreboard slice.
//   FSEL_W     : forwarding-select width for the default two producer stages
//   fsel_width : select width for an arbitrary number of producer stages
//   regidx_t   : architectural register index
//   FWD_RF     : select code meaning "read the register file"
package stage5_fwd_scoreboard_pkg;

  localparam int unsigned DEF_NUM_FWD = 2;
  localparam int unsigned FSEL_W      = $clog2(DEF_NUM_FWD + 1);

  typedef logic [4:0]        regidx_t;
  typedef logic [FSEL_W-1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF = '0;

  function automatic int unsigned fsel_width(input int unsigned num_fwd);
    return $clog2(num_fwd + 1);
  endfunction

endpackage

// File: rtl/stage5_fwd_prio_sel.sv
// Youngest-match forwarding select for one execute-stage operand.
//   src_reg : operand register index
//   fwd_wen / fwd_rd / fwd_rdy : per producer stage (0 youngest) write enable,
//             destination register and data-ready flag
//   sel     : 0 = register file, k+1 = producer stage k
//   sel_rdy : data from the selected source is available (1 for the register file)
module stage5_fwd_prio_sel
  import stage5_fwd_scoreboard_pkg::*;
#(
  parameter  int unsigned NUM_FWD = 2,
  localparam int unsigned SEL_W   = fsel_width(NUM_FWD)
) (
  input  logic [4:0]           src_reg,
  input  logic [NUM_FWD-1:0]   fwd_wen,
  input  logic [NUM_FWD*5-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]   fwd_rdy,
  output logic [SEL_W-1:0]     sel,
  output logic                 sel_rdy
);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    sel     = SEL_W'(FWD_RF);
    sel_rdy = 1'b1;
    if (src_reg != '0) begin
      for (int unsigned i = 0; i < NUM_FWD; i++) begin
        if (fwd_wen[NUM_FWD-1-i] && (fwd_rd[(NUM_FWD-1-i)*5 +: 5] == src_reg)) begin
          sel     = SEL_W'(NUM_FWD - i);
          sel_rdy = fwd_rdy[NUM_FWD-1-i];
        end
      end
    end
  end

endmodule

// File: rtl/stage5_fwd_scoreboard.sv
// Execute-stage operand forwarding select plus multicycle-op register scoreboard.
// Optional feature macro: STAGE5_SCOREBOARD_EN (scoreboard present when defined;
// otherwise busy_vec/mc_full/sb_err are 0, mc_* inputs are ignored and stall
// comes from load-use hazards only).
//   CLK, RST              : clock, synchronous active-high reset
//   src_valid, src_reg    : per-operand read enable and register index
//   fwd_wen/fwd_rd/fwd_rdy: per producer stage (0 = mem, youngest)
//   fwd_sel               : per-operand select, 0 = RF, k+1 = stage k
//   mc_issue/mc_rd        : multicycle op issue and destination
//   mc_done/mc_done_rd    : multicycle op completion and destination
//   stall                 : hold execute and earlier stages
//   mc_full/busy_vec/sb_err: outstanding limit reached, busy bits, error pulse
module stage5_fwd_scoreboard
  import stage5_fwd_scoreboard_pkg::*;
#(
  parameter  int unsigned NUM_SRC = 2,
  parameter  int unsigned NUM_FWD = 2,
  parameter  int unsigned MAX_OUT = 4,
  localparam int unsigned SEL_W   = fsel_width(NUM_FWD)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*5-1:0]     src_reg,
  input  logic [NUM_FWD-1:0]       fwd_wen,
  input  logic [NUM_FWD*5-1:0]     fwd_rd,
  input  logic [NUM_FWD-1:0]       fwd_rdy,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  input  logic                     mc_issue,
  input  logic [4:0]               mc_rd,
  input  logic                     mc_done,
  input  logic [4:0]               mc_done_rd,
  output logic                     stall,
  output logic                     mc_full,
  output logic [31:0]              busy_vec,
  output logic                     sb_err
);

  logic [NUM_SRC-1:0] src_rdy;
  logic               lu_hazard;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    stage5_fwd_prio_sel #(
      .NUM_FWD (NUM_FWD)
    ) u_sel (
      .src_reg (src_reg[s*5 +: 5]),
      .fwd_wen (fwd_wen),
      .fwd_rd  (fwd_rd),
      .fwd_rdy (fwd_rdy),
      .sel     (fwd_sel[s*SEL_W +: SEL_W]),
      .sel_rdy (src_rdy[s])
    );
  end

  always_comb begin
    lu_hazard = 1'b0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (src_valid[s] && (fwd_sel[s*SEL_W +: SEL_W] != '0) && !src_rdy[s])
        lu_hazard = 1'b1;
    end
  end

`ifdef STAGE5_SCOREBOARD_EN
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q;
  logic             sb_hazard, waw_hazard, issue_ok, done_ok;
  regidx_t          rd_i;

  assign mc_full  = (count_q == CNT_W'(MAX_OUT));
  assign busy_vec = busy_q;
  assign sb_err   = err_q;

  always_comb begin
    sb_hazard = 1'b0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      rd_i = src_reg[s*5 +: 5];
      if (src_valid[s] && (rd_i != '0) && busy_q[rd_i])
        sb_hazard = 1'b1;
    end
  end

  assign waw_hazard = mc_issue && busy_q[mc_rd] && !(mc_done && (mc_done_rd == mc_rd));
  assign stall      = lu_hazard || sb_hazard || (mc_issue && mc_full) || waw_hazard;
  assign issue_ok   = mc_issue && !stall;
  assign done_ok    = mc_done && (count_q != '0) && busy_q[mc_done_rd];

  // Clear before set so an issue and done on the same register leave it busy.
  always_comb begin
    busy_d = busy_q;
    if (done_ok)
      busy_d[mc_done_rd] = 1'b0;
    if (issue_ok && (mc_rd != '0))
      busy_d[mc_rd] = 1'b1;
    count_d = count_q;
    case ({issue_ok, done_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      err_q   <= mc_done && !done_ok;
    end
  end
`else
  localparam int unsigned unused_max_out = MAX_OUT;
  logic unused_mc;

  assign unused_mc = ^{mc_issue, mc_rd, mc_done, mc_done_rd, CLK, RST};
  assign busy_vec  = '0;
  assign mc_full   = 1'b0;
  assign sb_err    = 1'b0;
  assign stall     = lu_hazard;
`endif

endmodule

// File: tb/tb_stage5_fwd_scoreboard.sv
module tb_stage5_fwd_scoreboard;
  import stage5_fwd_scoreboard_pkg::*;

  localparam int NS   = 2;
  localparam int NF   = 2;
  localparam int SW   = FSEL_W;
  localparam int MAXO = 4;
`ifdef STAGE5_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST;
  logic [NS-1:0]    src_valid;
  logic [NS*5-1:0]  src_reg;
  logic [NF-1:0]    fwd_wen, fwd_rdy;
  logic [NF*5-1:0]  fwd_rd;
  logic [NS*SW-1:0] fwd_sel;
  logic             mc_issue, mc_done, stall, mc_full, sb_err;
  logic [4:0]       mc_rd, mc_done_rd;
  logic [31:0]      busy_vec;

  always #5 CLK = ~CLK;

  stage5_fwd_scoreboard #(
    .NUM_SRC (NS),
    .NUM_FWD (NF),
    .MAX_OUT (MAXO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .src_valid  (src_valid),
    .src_reg    (src_reg),
    .fwd_wen    (fwd_wen),
    .fwd_rd     (fwd_rd),
    .fwd_rdy    (fwd_rdy),
    .fwd_sel    (fwd_sel),
    .mc_issue   (mc_issue),
    .mc_rd      (mc_rd),
    .mc_done    (mc_done),
    .mc_done_rd (mc_done_rd),
    .stall      (stall),
    .mc_full    (mc_full),
    .busy_vec   (busy_vec),
    .sb_err     (sb_err)
  );

  typedef struct {
    logic [NS*SW-1:0] sel;
    logic             stall;
    logic [31:0]      busy;
    logic             full;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  // Reference state: set of busy registers, outstanding count, pending error pulse.
  bit m_busy[32];
  int m_count;
  bit m_err;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: one expected response per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fwd_sel",  32'(fwd_sel),  32'(e.sel));
        chk("stall",    32'(stall),    32'(e.stall));
        chk("busy_vec", busy_vec,      e.busy);
        chk("mc_full",  32'(mc_full),  32'(e.full));
        chk("sb_err",   32'(sb_err),   32'(e.err));
      end
    end
  end

  task automatic clr();
    src_valid = '0; src_reg = '0; fwd_wen = '0; fwd_rd = '0; fwd_rdy = '1;
    mc_issue = 0; mc_rd = '0; mc_done = 0; mc_done_rd = '0;
  endtask

  // Predict this cycle's outputs from the rules, queue them, advance the model.
  task automatic step();
    exp_t    e;
    bit      lu = 0, sbh = 0, full, waw, st, acc, dok, rdyb;
    int      sel;
    regidx_t r;
    e.sel = '0;
    for (int s = 0; s < NS; s++) begin
      r = src_reg[s*5 +: 5];
      sel = 0; rdyb = 1;
      if (r != 0)
        for (int k = 0; k < NF; k++)
          if (sel == 0 && fwd_wen[k] && fwd_rd[k*5 +: 5] == r) begin
            sel = k + 1; rdyb = fwd_rdy[k];
          end
      e.sel[s*SW +: SW] = SW'(sel);
      if (src_valid[s] && sel != 0 && !rdyb) lu = 1;
      if (SB && src_valid[s] && r != 0 && m_busy[r]) sbh = 1;
    end
    full = SB && (m_count == MAXO);
    waw  = SB && mc_issue && m_busy[mc_rd] && !(mc_done && mc_done_rd == mc_rd);
    st   = lu || sbh || (mc_issue && full) || waw;
    e.stall = st;
    for (int i = 0; i < 32; i++) e.busy[i] = m_busy[i];
    e.full = full;
    e.err  = m_err;
    exp_q.push_back(e);
    if (RST) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_count = 0; m_err = 0;
    end else if (SB) begin
      acc = mc_issue && !st;
      dok = mc_done && m_count > 0 && m_busy[mc_done_rd];
      m_err = mc_done && !dok;
      if (dok) m_busy[mc_done_rd] = 0;
      if (acc && mc_rd != 0) m_busy[mc_rd] = 1;
      m_count = m_count + int'(acc) - int'(dok);
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    int busy_list[$];
    clr(); RST = 1;
    foreach (m_busy[i]) m_busy[i] = 0;
    m_count = 0; m_err = 0;
    repeat (2) @(posedge CLK);
    #1;
    step();                       // reset state
    RST = 0;

    // Both stages write x5: youngest (stage 0) wins.
    clr(); src_valid = 2'b01; src_reg[4:0] = 5; fwd_wen = 2'b11;
    fwd_rd = {5'd5, 5'd5}; step();
    // x0 never forwards.
    clr(); src_valid = 2'b10; src_reg[9:5] = 0; fwd_wen = 2'b01; step();
    // Load-use: load in mem not ready, then ready in wb.
    clr(); src_valid = 2'b01; src_reg[4:0] = 7; fwd_wen = 2'b01; fwd_rd[4:0] = 7;
    fwd_rdy = 2'b10; step();
    clr(); src_valid = 2'b01; src_reg[4:0] = 7; fwd_wen = 2'b10; fwd_rd[9:5] = 7; step();
    // Issue x9, read it while busy, complete it, read again.
    clr(); mc_issue = 1; mc_rd = 9; step();
    clr(); src_valid = 2'b01; src_reg[4:0] = 9; step(); step();
    mc_done = 1; mc_done_rd = 9; step();
    clr(); src_valid = 2'b01; src_reg[4:0] = 9; step();
    // Fill to MAX_OUT, fifth issue stalls, even alongside a done.
    for (int i = 1; i <= 4; i++) begin clr(); mc_issue = 1; mc_rd = 5'(i); step(); end
    clr(); mc_issue = 1; mc_rd = 5; step();
    mc_done = 1; mc_done_rd = 1; step();
    clr(); mc_issue = 1; mc_rd = 5; step();
    // Same-register issue and done: set wins.
    clr(); mc_issue = 1; mc_rd = 2; mc_done = 1; mc_done_rd = 2; step();
    // Done to a non-busy register.
    clr(); mc_done = 1; mc_done_rd = 12; step();
    clr(); step(); step();
    // Reset discards outstanding ops; a later done is an error.
    RST = 1; step(); RST = 0;
    clr(); mc_done = 1; mc_done_rd = 3; step();
    clr(); step();

    for (int n = 0; n < 1500; n++) begin
      clr();
      RST       = ($urandom_range(0, 299) == 0);
      src_valid = NS'($urandom);
      for (int s = 0; s < NS; s++) src_reg[s*5 +: 5] = 5'($urandom_range(0, 7));
      fwd_wen = NF'($urandom);
      for (int k = 0; k < NF; k++) begin
        fwd_rd[k*5 +: 5] = 5'($urandom_range(0, 7));
        fwd_rdy[k]       = ($urandom_range(0, 3) != 0);
      end
      mc_issue = ($urandom_range(0, 2) == 0);
      mc_rd    = 5'(($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 7));
      mc_done  = ($urandom_range(0, 2) == 0);
      busy_list.delete();
      for (int i = 0; i < 32; i++) if (m_busy[i]) busy_list.push_back(i);
      if (busy_list.size() > 0 && $urandom_range(0, 3) != 0)
        mc_done_rd = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
      else
        mc_done_rd = 5'($urandom_range(0, 15));
      step();
    end

    clr();
    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge CLK);
    if (exp_q.size() > 0) begin
      tests++; failed++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
